// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// pwm_capture: measures high time and period of a PWM input sampled on clk1ms.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a third sync flop and reject 1-cycle pulses.
module pwm_capture #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk1ms,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    HIGH = 2'b10,
    LOW  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  logic [SYNC_N-1:0] sync_q;
  logic              s_prev_q;
  logic              s_in;
  logic              rise;
  logic              fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]  high_time_q, high_time_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk1ms or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_N-2:0], pwm_in};
      s_prev_q <= s_in;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Level only moves once two consecutive synchronized samples agree.
  assign s_in = (sync_q[1] == sync_q[2]) ? sync_q[1] : s_prev_q;
`else
  assign s_in = sync_q[1];
`endif

  assign rise = s_in & ~s_prev_q;
  assign fall = ~s_in & s_prev_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk1ms or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      pcnt_q      <= '0;
      idle_q      <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      idle_q      <= idle_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    idle_d      = idle_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!enable) begin
      state_d   = IDLE;
      hcnt_d    = '0;
      pcnt_d    = '0;
      idle_d    = '0;
      timeout_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = ARM;
    end else if (!rise && !fall && idle_q == IDLE_LAST) begin
      // Input went quiet: abandon the partial measurement but keep the last result.
      timeout_d = 1'b1;
      state_d   = ARM;
      hcnt_d    = '0;
      pcnt_d    = '0;
      idle_d    = '0;
    end else begin
      idle_d = (rise || fall) ? '0 : idle_q + 1'b1;
      case (state_q)
        ARM: begin
          if (rise) begin
            state_d   = HIGH;
            hcnt_d    = CNT_ONE;
            pcnt_d    = CNT_ONE;
            timeout_d = 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            pcnt_d  = sat_inc(pcnt_q);
          end else begin
            hcnt_d = sat_inc(hcnt_q);
            pcnt_d = sat_inc(pcnt_q);
          end
        end
        LOW: begin
          if (rise) begin
            high_time_d = hcnt_q;
            period_d    = pcnt_q;
            valid_d     = 1'b1;
            hcnt_d      = CNT_ONE;
            pcnt_d      = CNT_ONE;
            state_d     = HIGH;
            timeout_d   = 1'b0;
          end else begin
            pcnt_d = sat_inc(pcnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign high_time = high_time_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Testbench for pwm_capture: two configurations (8-bit/200 and 4-bit/15) checked every cycle
// against a timestamp-based model, plus directed literal checks.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm = 1'b0;
  logic en  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] dut_ht  [2];
  logic [7:0] dut_per [2];
  logic       dut_val [2];
  logic       dut_to  [2];
  logic [1:0] dut_st  [2];

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int W    = (gi == 0) ? 8 : 4;
    localparam int TO   = (gi == 0) ? 200 : 15;
    localparam int MAXV = (1 << W) - 1;

    logic [W-1:0] ht_w, per_w;
    logic         val_w, to_w;
    logic [1:0]   st_w;

    pwm_capture #(.CNT_W(W), .TIMEOUT(TO)) u_dut (
      .clk1ms   (clk),
      .reset    (rst),
      .pwm_in   (pwm),
      .enable   (en),
      .high_time(ht_w),
      .period   (per_w),
      .valid    (val_w),
      .timeout  (to_w),
      .state    (st_w)
    );

    assign dut_ht[gi]  = 8'(ht_w);
    assign dut_per[gi] = 8'(per_w);
    assign dut_val[gi] = val_w;
    assign dut_to[gi]  = to_w;
    assign dut_st[gi]  = st_w;

    // Model: pin seen two samples late; result = timestamps of accepted edges.
    int       k, t_rise, t_fall, t_edge, m_ht, m_per, m_st;
    bit [2:0] hist;
    bit       f_prev, active, have_rise, have_fall, m_val, m_to;

    function automatic int sat(input int v);
      return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_step();
      bit f_cur, r, f;
      if (rst) begin
        hist = '0; f_prev = 0; active = 0; have_rise = 0; have_fall = 0;
        m_ht = 0; m_per = 0; m_val = 0; m_to = 0; m_st = 0;
        return;
      end
      k++;
      f_cur = hist[1];
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      if (hist[1] != hist[2]) f_cur = f_prev;
`endif
      r = f_cur & ~f_prev;
      f = ~f_cur & f_prev;
      f_prev = f_cur;
      hist = {hist[1:0], pwm};
      m_val = 0;
      if (!en) begin
        active = 0; have_rise = 0; have_fall = 0; m_to = 0;
      end else if (!active) begin
        active = 1; t_edge = k;
      end else begin
        if (r || f) t_edge = k;
        if (r) begin
          if (have_rise && have_fall) begin
            m_val = 1;
            m_per = sat(k - t_rise);
            m_ht  = sat(t_fall - t_rise);
          end
          have_rise = 1; have_fall = 0; t_rise = k; m_to = 0;
        end else if (f) begin
          if (have_rise) begin
            have_fall = 1; t_fall = k;
          end
        end else if (k - t_edge == TO) begin
          m_to = 1; have_rise = 0; have_fall = 0; t_edge = k;
        end
      end
      m_st = !active ? 0 : !have_rise ? 1 : !have_fall ? 2 : 3;
    endtask

    initial forever begin
      @(posedge clk or posedge rst);
      model_step();
    end

    initial forever begin
      @(negedge clk);
      cmp($sformatf("i%0d_high_time", gi), int'(ht_w),  m_ht);
      cmp($sformatf("i%0d_period", gi),    int'(per_w), m_per);
      cmp($sformatf("i%0d_valid", gi),     int'(val_w), int'(m_val));
      cmp($sformatf("i%0d_timeout", gi),   int'(to_w),  int'(m_to));
      cmp($sformatf("i%0d_state", gi),     int'(st_w),  m_st);
    end
  end

  task automatic step(input logic v);
    pwm = v;
    @(posedge clk);
    #2;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #2;
    cmp("rst_state", int'(dut_st[0]), 0);
    cmp("rst_high_time", int'(dut_ht[0]), 0);
    cmp("rst_period", int'(dut_per[0]), 0);
    cmp("rst_valid", int'(dut_val[0]), 0);
    cmp("rst_timeout", int'(dut_to[0]), 0);
    rst = 1'b0;
    en  = 1'b1;

    wave(2, 18, 6);
    cmp("p2_18_high_time", int'(dut_ht[0]), 2);
    cmp("p2_18_period", int'(dut_per[0]), 20);

    wave(10, 10, 4);
    cmp("p10_10_high_time", int'(dut_ht[0]), 10);
    cmp("p10_10_period", int'(dut_per[0]), 20);
    cmp("sat_high_time", int'(dut_ht[1]), 10);
    cmp("sat_period", int'(dut_per[1]), 15);

    wave(5, 15, 3);
    cmp("p5_15_high_time", int'(dut_ht[0]), 5);
    cmp("p5_15_period", int'(dut_per[0]), 20);
    cmp("sat5_period", int'(dut_per[1]), 15);

    repeat (205) step(1'b0);
    cmp("to_timeout", int'(dut_to[0]), 1);
    cmp("to_state", int'(dut_st[0]), 1);
    cmp("to_hold_high_time", int'(dut_ht[0]), 5);
    cmp("to_hold_period", int'(dut_per[0]), 20);
    repeat (4) step(1'b1);
    cmp("to_clear", int'(dut_to[0]), 0);
    cmp("to_clear_state", int'(dut_st[0]), 2);

    // Reset in the middle of a high phase.
    repeat (6) step(1'b0);
    repeat (5) step(1'b1);
    rst = 1'b1;
    step(1'b1);
    cmp("mid_rst_state", int'(dut_st[0]), 0);
    cmp("mid_rst_period", int'(dut_per[0]), 0);
    cmp("mid_rst_high_time", int'(dut_ht[0]), 0);
    rst = 1'b0;
    wave(3, 7, 3);

    // Pin-to-valid latency.
    repeat (5) step(1'b0);
    step(1'b1);
    step(1'b1);
    cmp("lat_valid_early", int'(dut_val[0]), 0);
    step(1'b1);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    cmp("lat_valid_early2", int'(dut_val[0]), 0);
    step(1'b1);
`endif
    cmp("lat_valid", int'(dut_val[0]), 1);

    // One-cycle glitch inside the low phase.
    repeat (4) begin
      repeat (2) step(1'b1);
      repeat (8) step(1'b0);
      step(1'b1);
      repeat (9) step(1'b0);
    end
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    cmp("glitch_period", int'(dut_per[0]), 20);
    cmp("glitch_high_time", int'(dut_ht[0]), 2);
`else
    cmp("glitch_period", int'(dut_per[0]), 10);
    cmp("glitch_high_time", int'(dut_ht[0]), 2);
`endif

    en = 1'b0;
    step(1'b0);
    step(1'b0);
    cmp("dis_state", int'(dut_st[0]), 0);
    cmp("dis_timeout", int'(dut_to[0]), 0);
    en = 1'b1;

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)));
        en = 1'b1;
      end else if (r == 1) begin
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
      end else if (r == 2) begin
        repeat ($urandom_range(200, 230)) step(1'b0);
      end else if (r == 3) begin
        repeat (30) step(1'($urandom_range(0, 1)));
      end else begin
        wave($urandom_range(1, 12), $urandom_range(1, 12), 1);
      end
    end
    repeat (5) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
